// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq_pkg: shared widths, opcode map, state codes, ALU / PC-select codes
// and the opcode-class type used by the ONC-16 control sequencer.
package ctrl_seq_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned IMM_W  = 8;
    localparam int unsigned OPC_W  = 5;

    // Opcode map, ir[15:11]. Unlisted codes execute as NOP.
    localparam logic [OPC_W-1:0] OpcAdd  = 5'd0;
    localparam logic [OPC_W-1:0] OpcSub  = 5'd1;
    localparam logic [OPC_W-1:0] OpcAnd  = 5'd2;
    localparam logic [OPC_W-1:0] OpcOr   = 5'd3;
    localparam logic [OPC_W-1:0] OpcXor  = 5'd4;
    localparam logic [OPC_W-1:0] OpcAddi = 5'd5;
    localparam logic [OPC_W-1:0] OpcAndi = 5'd6;
    localparam logic [OPC_W-1:0] OpcOri  = 5'd7;
    localparam logic [OPC_W-1:0] OpcXori = 5'd8;
    localparam logic [OPC_W-1:0] OpcLd   = 5'd9;
    localparam logic [OPC_W-1:0] OpcSt   = 5'd10;
    localparam logic [OPC_W-1:0] OpcBez  = 5'd11;
    localparam logic [OPC_W-1:0] OpcJmp  = 5'd12;
    localparam logic [OPC_W-1:0] OpcNop  = 5'd13;
    localparam logic [OPC_W-1:0] OpcHalt = 5'd14;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluXor = 3'b100;

    localparam logic [1:0] PcInc    = 2'b00;
    localparam logic [1:0] PcBranch = 2'b01;
    localparam logic [1:0] PcJump   = 2'b10;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        ClsAlu,
        ClsLd,
        ClsSt,
        ClsBez,
        ClsJmp,
        ClsNop,
        ClsHalt
    } op_class_e;

    function automatic logic [OPC_W-1:0] opc_of(input logic [DATA_W-1:0] instr);
        return instr[DATA_W-1 -: OPC_W];
    endfunction

endpackage

// File: rtl/ctrl_seq_if.sv
// ctrl_seq_if: shared memory-port handshake between the sequencer and memory.
//   mem_req      request, level-held until the ack cycle
//   mem_we       store when 1
//   mem_addr_sel 0 = PC, 1 = ALU result
//   mem_ack      completion, only meaningful while mem_req = 1
interface ctrl_seq_if;
    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr_sel,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr_sel,
        output mem_ack
    );
endinterface

// File: rtl/ctrl_seq_decode.sv
// ctrl_decode: combinational opcode decoder.
//   opc       in   instruction opcode field
//   op_class  out  instruction class (undefined opcodes map to ClsNop)
//   ext_sel   out  0 = zero-extend immediate, 1 = sign-extend
//   alu_op    out  ALU operation for EXEC/MEM/WB
//   alu_b_sel out  0 = register rt, 1 = extender output
module ctrl_decode
    import ctrl_seq_pkg::*;
(
    input  logic [OPC_W-1:0] opc,
    output op_class_e        op_class,
    output logic             ext_sel,
    output logic [2:0]       alu_op,
    output logic             alu_b_sel
);

    always_comb begin
        op_class  = ClsNop;
        ext_sel   = 1'b0;
        alu_op    = AluAdd;
        alu_b_sel = 1'b0;
        case (opc)
            OpcAdd: op_class = ClsAlu;
            OpcSub: begin
                op_class = ClsAlu;
                alu_op   = AluSub;
            end
            OpcAnd: begin
                op_class = ClsAlu;
                alu_op   = AluAnd;
            end
            OpcOr: begin
                op_class = ClsAlu;
                alu_op   = AluOr;
            end
            OpcXor: begin
                op_class = ClsAlu;
                alu_op   = AluXor;
            end
            OpcAddi: begin
                op_class  = ClsAlu;
                ext_sel   = 1'b1;
                alu_b_sel = 1'b1;
            end
            OpcAndi: begin
                op_class  = ClsAlu;
                alu_op    = AluAnd;
                alu_b_sel = 1'b1;
            end
            OpcOri: begin
                op_class  = ClsAlu;
                alu_op    = AluOr;
                alu_b_sel = 1'b1;
            end
            OpcXori: begin
                op_class  = ClsAlu;
                alu_op    = AluXor;
                alu_b_sel = 1'b1;
            end
            OpcLd: begin
                op_class  = ClsLd;
                ext_sel   = 1'b1;
                alu_b_sel = 1'b1;
            end
            OpcSt: begin
                op_class  = ClsSt;
                ext_sel   = 1'b1;
                alu_b_sel = 1'b1;
            end
            OpcBez: begin
                op_class = ClsBez;
                ext_sel  = 1'b1;
            end
            OpcJmp:  op_class = ClsJmp;
            OpcHalt: op_class = ClsHalt;
            default: op_class = ClsNop;
        endcase
    end

endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle control sequencer for the ONC-16 core.
//   clk, rst      clock and synchronous active-high reset
//   ir            instruction register contents (valid from DECODE on)
//   zero_flag     rs == 0 comparator, used by BEZ in EXEC
//   mem           memory handshake (ctrl_seq_if master side)
//   ir_we, pc_we, pc_sel      fetch / PC update controls
//   ext_sel, alu_b_sel, alu_op  immediate extender and ALU controls
//   rf_we, rf_wsel            register file write controls
//   halted, state             status and debug state code
module ctrl_seq
    import ctrl_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ir,
    input  logic              zero_flag,
    ctrl_seq_if.master        mem,
    output logic              ir_we,
    output logic              pc_we,
    output logic [1:0]        pc_sel,
    output logic              ext_sel,
    output logic              alu_b_sel,
    output logic [2:0]        alu_op,
    output logic              rf_we,
    output logic              rf_wsel,
    output logic              halted,
    output logic [2:0]        state
);

    state_e    state_q, state_d;
    op_class_e dec_class;
    logic      dec_ext_sel;
    logic [2:0] dec_alu_op;
    logic      dec_alu_b_sel;

    // Immediate and register fields are consumed by the datapath, not here.
    logic unused_ir;
    assign unused_ir = ^ir[DATA_W-OPC_W-1:0];

    ctrl_decode u_decode (
        .opc       (opc_of(ir)),
        .op_class  (dec_class),
        .ext_sel   (dec_ext_sel),
        .alu_op    (dec_alu_op),
        .alu_b_sel (dec_alu_b_sel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch: begin
                if (mem.mem_ack) state_d = StDecode;
            end
            StDecode: begin
                state_d = (dec_class == ClsHalt) ? StHalt : StExec;
            end
            StExec: begin
                case (dec_class)
                    ClsAlu:       state_d = StWb;
                    ClsLd, ClsSt: state_d = StMem;
                    default:      state_d = StFetch;
                endcase
            end
            StMem: begin
                if (mem.mem_ack) state_d = (dec_class == ClsLd) ? StWb : StFetch;
            end
            StWb:    state_d = StFetch;
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    // Everything is forced low while rst is high so an aborted instruction
    // cannot fire an enable in the reset cycle.
    always_comb begin
        mem.mem_req      = 1'b0;
        mem.mem_we       = 1'b0;
        mem.mem_addr_sel = 1'b0;
        ir_we            = 1'b0;
        pc_we            = 1'b0;
        pc_sel           = PcInc;
        ext_sel          = 1'b0;
        alu_b_sel        = 1'b0;
        alu_op           = AluAdd;
        rf_we            = 1'b0;
        rf_wsel          = 1'b0;
        halted           = 1'b0;
        state            = rst ? 3'b000 : 3'(state_q);
        if (!rst) begin
            case (state_q)
                StFetch: begin
                    mem.mem_req = 1'b1;
                    if (mem.mem_ack) begin
                        ir_we = 1'b1;
                        pc_we = 1'b1;
                    end
                end
                StDecode: begin
                    ext_sel = dec_ext_sel;
                end
                StExec: begin
                    ext_sel   = dec_ext_sel;
                    alu_op    = dec_alu_op;
                    alu_b_sel = dec_alu_b_sel;
                    if (dec_class == ClsJmp) begin
                        pc_we  = 1'b1;
                        pc_sel = PcJump;
                    end else if (dec_class == ClsBez && zero_flag) begin
                        pc_we  = 1'b1;
                        pc_sel = PcBranch;
                    end
                end
                StMem: begin
                    mem.mem_req      = 1'b1;
                    mem.mem_addr_sel = 1'b1;
                    mem.mem_we       = (dec_class == ClsSt);
                    ext_sel          = dec_ext_sel;
                    alu_op           = dec_alu_op;
                    alu_b_sel        = dec_alu_b_sel;
                end
                StWb: begin
                    rf_we     = 1'b1;
                    rf_wsel   = (dec_class == ClsLd);
                    ext_sel   = dec_ext_sel;
                    alu_op    = dec_alu_op;
                    alu_b_sel = dec_alu_b_sel;
                end
                StHalt: begin
                    halted = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: directed bench for ctrl_seq. Each instruction is expanded into
// a per-cycle list of expected outputs from its class, wait counts and flags;
// one compare process checks every cycle against that list.
module tb_ctrl_seq;
    import ctrl_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ir;
    logic        zero_flag;
    logic        ir_we, pc_we, ext_sel, alu_b_sel, rf_we, rf_wsel, halted;
    logic [1:0]  pc_sel;
    logic [2:0]  alu_op, state;

    ctrl_seq_if mem_bus ();

    ctrl_seq dut (
        .clk       (clk),
        .rst       (rst),
        .ir        (ir),
        .zero_flag (zero_flag),
        .mem       (mem_bus),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pc_sel    (pc_sel),
        .ext_sel   (ext_sel),
        .alu_b_sel (alu_b_sel),
        .alu_op    (alu_op),
        .rf_we     (rf_we),
        .rf_wsel   (rf_wsel),
        .halted    (halted),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] vec;
        logic        ack;
        logic        zf;
        logic        r;
        logic [15:0] instr;
    } step_t;

    step_t       q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          rf_pulses = 0;
    logic [17:0] cur_exp;
    bit          cur_valid = 0;
    string       cur_name = "";
    logic [17:0] dut_vec;

    assign dut_vec = {state, mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr_sel, ir_we,
                      pc_we, pc_sel, ext_sel, alu_b_sel, alu_op, rf_we, rf_wsel, halted};

    function automatic logic [17:0] pk(input logic [2:0] st, input logic req, input logic we,
                                       input logic asel, input logic irwe, input logic pcwe,
                                       input logic [1:0] psel, input logic ext, input logic bsel,
                                       input logic [2:0] aop, input logic rfwe, input logic rfws,
                                       input logic hlt);
        return {st, req, we, asel, irwe, pcwe, psel, ext, bsel, aop, rfwe, rfws, hlt};
    endfunction

    function automatic void push(input logic [17:0] v, input logic ack, input logic zf,
                                 input logic r, input logic [15:0] instr);
        step_t s;
        s.vec = v; s.ack = ack; s.zf = zf; s.r = r; s.instr = instr;
        q.push_back(s);
    endfunction

    // Expand one instruction into its expected cycles; returns the cycle count.
    // kind: 0 alu, 1 ld, 2 st, 3 bez, 4 jmp, 5 nop, 6 halt
    function automatic int build(input logic [4:0] opc, input logic [7:0] imm, input int fw,
                                 input int mw, input logic zf, input logic noise);
        logic [15:0] instr;
        int          kind, n;
        logic        ext, bsel, pcwe;
        logic [1:0]  psel;
        logic [2:0]  aop;
        instr = {opc, 3'b000, imm};
        ext = 0; bsel = 0; aop = 3'b000; kind = 5; n = 0;
        case (opc)
            OpcAdd:  kind = 0;
            OpcSub:  begin kind = 0; aop = 3'b001; end
            OpcAnd:  begin kind = 0; aop = 3'b010; end
            OpcOr:   begin kind = 0; aop = 3'b011; end
            OpcXor:  begin kind = 0; aop = 3'b100; end
            OpcAddi: begin kind = 0; ext = 1; bsel = 1; end
            OpcAndi: begin kind = 0; aop = 3'b010; bsel = 1; end
            OpcOri:  begin kind = 0; aop = 3'b011; bsel = 1; end
            OpcXori: begin kind = 0; aop = 3'b100; bsel = 1; end
            OpcLd:   begin kind = 1; ext = 1; bsel = 1; end
            OpcSt:   begin kind = 2; ext = 1; bsel = 1; end
            OpcBez:  begin kind = 3; ext = 1; end
            OpcJmp:  kind = 4;
            OpcHalt: kind = 6;
            default: kind = 5;
        endcase
        for (int i = 0; i < fw; i++) begin
            push(pk(3'd0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 0), 0, noise, 0, instr);
            n++;
        end
        push(pk(3'd0, 1, 0, 0, 1, 1, 2'b00, 0, 0, 3'b000, 0, 0, 0), 1, noise, 0, instr);
        n++;
        push(pk(3'd1, 0, 0, 0, 0, 0, 2'b00, ext, 0, 3'b000, 0, 0, 0), noise, noise, 0, instr);
        n++;
        if (kind == 6) begin
            push(pk(3'd5, 0, 0, 0, 0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 1), noise, noise, 0, instr);
            return n + 1;
        end
        pcwe = (kind == 4) || (kind == 3 && zf);
        psel = (kind == 4) ? 2'b10 : ((kind == 3 && zf) ? 2'b01 : 2'b00);
        push(pk(3'd2, 0, 0, 0, 0, pcwe, psel, ext, bsel, aop, 0, 0, 0), noise,
             (kind == 3) ? zf : noise, 0, instr);
        n++;
        if (kind == 1 || kind == 2) begin
            for (int i = 0; i <= mw; i++) begin
                push(pk(3'd3, 1, kind == 2, 1, 0, 0, 2'b00, ext, bsel, aop, 0, 0, 0),
                     i == mw, noise, 0, instr);
                n++;
            end
        end
        if (kind == 0 || kind == 1) begin
            push(pk(3'd4, 0, 0, 0, 0, 0, 2'b00, ext, bsel, aop, 1, kind == 1, 0), noise, noise,
                 0, instr);
            n++;
        end
        return n;
    endfunction

    task automatic run(input string name);
        rf_pulses = 0;
        while (q.size() > 0) begin
            step_t s;
            s = q.pop_front();
            @(posedge clk);
            #1;
            rst             = s.r;
            mem_bus.mem_ack = s.ack;
            zero_flag       = s.zf;
            ir              = s.instr;
            cur_exp         = s.vec;
            cur_name        = name;
            cur_valid       = 1;
        end
        @(negedge clk);
        #1;
    endtask

    function automatic void check_int(input string nm, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s got %0d want %0d", nm, got, want);
        end
    endfunction

    always @(negedge clk) begin
        if (cur_valid) begin
            vectors++;
            if (dut_vec !== cur_exp) begin
                miscompares++;
                $display("FAIL %s t=%0t outputs got %h want %h", cur_name, $time, dut_vec,
                         cur_exp);
            end
            if (rf_we === 1'b1) rf_pulses++;
        end
    end

    initial begin
        int n;
        logic [4:0] alu_ops[8];
        rst = 1'b1;
        mem_bus.mem_ack = 1'b1;
        zero_flag = 1'b1;
        ir = {OpcAddi, 11'h0FF};
        alu_ops = '{OpcAdd, OpcSub, OpcAnd, OpcOr, OpcXor, OpcAndi, OpcXori, 5'd31};

        // Reset with noisy inputs: every output must be 0.
        for (int i = 0; i < 2; i++) push(18'h0, 1, 1, 1, {OpcLd, 11'h0AA});
        run("reset");

        n = build(OpcAddi, 8'hFF, 0, 0, 0, 0);
        check_int("addi_cycles", n, 4);
        run("addi");
        check_int("addi_rf_we_pulses", rf_pulses, 1);

        n = build(OpcOri, 8'hFF, 0, 0, 0, 1);
        run("ori");
        check_int("ori_rf_we_pulses", rf_pulses, 1);

        n = build(OpcLd, 8'h10, 3, 3, 0, 0);
        check_int("ld_cycles", n, 11);
        run("ld_wait");
        check_int("ld_rf_we_pulses", rf_pulses, 1);

        n = build(OpcBez, 8'hF0, 0, 0, 1, 0);
        check_int("bez_taken_cycles", n, 3);
        run("bez_taken");
        n = build(OpcBez, 8'hF0, 0, 0, 0, 1);
        check_int("bez_not_taken_cycles", n, 3);
        run("bez_not_taken");

        n = build(OpcSt, 8'h80, 1, 0, 0, 1);
        check_int("st_cycles", n, 5);
        run("st");
        check_int("st_rf_we_pulses", rf_pulses, 0);

        n = build(OpcJmp, 8'h42, 0, 2, 0, 1);
        run("jmp");
        n = build(OpcNop, 8'h00, 2, 0, 0, 1);
        run("nop");
        foreach (alu_ops[i]) begin
            n = build(alu_ops[i], 8'h81, i % 2, 0, 0, 1'(i % 2));
            run("alu_mix");
        end

        // Reset lands in the MEM ack cycle of a store: nothing may fire.
        n = build(OpcSt, 8'h7F, 0, 0, 0, 0);
        void'(q.pop_back());
        push(18'h0, 1, 0, 1, {OpcSt, 11'h07F});
        run("st_reset");
        n = build(OpcAdd, 8'h00, 0, 0, 0, 0);
        run("after_reset");

        n = build(OpcHalt, 8'h00, 0, 0, 0, 0);
        check_int("halt_cycles", n, 3);
        for (int i = 0; i < 19; i++)
            push(pk(3'd5, 0, 0, 0, 0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 1), 1'(i % 2), 1,
                 0, {OpcAddi, 11'h0FF});
        run("halt");
        push(18'h0, 1, 1, 1, {OpcAddi, 11'h0FF});
        run("halt_reset");
        n = build(OpcAddi, 8'h01, 0, 0, 0, 0);
        run("restart");
        check_int("restart_rf_we_pulses", rf_pulses, 1);

        cur_valid = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
